// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan display: glyph table, blank glyph
// and the digit-index type.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] digit_t;

    // Segment order is bit0=a .. bit6=g, active-high.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-glyph decoder (active-high segments).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed hex display with frame-synchronous value reload so a
// scan never shows a mix of two values.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        sel_hi,
    input  logic        data_valid,
    output logic [6:0]  sm_duan,
    output logic [3:0]  sm_wei,
    output logic        frame_done
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]      WEI_POL  = {4{SEG_ACT_LOW}};
    localparam logic [6:0]      DUAN_POL = {7{SEG_ACT_LOW}};

    logic [CNT_W-1:0] cnt, cnt_next;
    digit_t           digit, digit_next;
    logic [15:0]      pending, shown, shown_next, capture_half;
    logic             tick, boundary, blank;
    logic [3:0]       nibble, wei_next;
    logic [6:0]       glyph, duan_next;

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    // Next-state logic; outputs are derived from next-state digit/shown so the
    // output registers move on the same edge as the digit index.
    always_comb begin
        capture_half = sel_hi ? data_in[31:16] : data_in[15:0];
        tick         = (cnt == CNT_LAST);
        boundary     = tick && (digit == 2'd3);
        cnt_next     = tick ? '0 : cnt + CNT_W'(1);
        digit_next   = tick ? digit + 2'd1 : digit;
        shown_next   = shown;
        if (boundary) begin
            shown_next = data_valid ? capture_half : pending;
        end
        nibble = shown_next[3:0];
        blank  = 1'b0;
        case (digit_next)
            2'd0: begin
                nibble = shown_next[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                nibble = shown_next[7:4];
                blank  = (shown_next[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = shown_next[11:8];
                blank  = (shown_next[15:8] == 8'h00);
            end
            default: begin
                nibble = shown_next[15:12];
                blank  = (shown_next[15:12] == 4'h0);
            end
        endcase
        duan_next = (LZ_BLANK && blank) ? SEG_BLANK : glyph;
        wei_next  = 4'b0001 << digit_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else begin
            cnt   <= cnt_next;
            digit <= digit_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 16'h0000;
            shown      <= 16'h0000;
            frame_done <= 1'b0;
            sm_wei     <= 4'b0001 ^ WEI_POL;
            sm_duan    <= 7'h3F ^ DUAN_POL;
        end else begin
            if (data_valid) begin
                pending <= capture_half;
            end
            shown      <= shown_next;
            frame_done <= boundary;
            sm_wei     <= wei_next ^ WEI_POL;
            sm_duan    <= duan_next ^ DUAN_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: three parameter variants against a time-based
// model, plus hand-computed glyph checks per test step.
module tb_seg7_scan_display;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = 32'h0;
    logic        sel_hi = 1'b0;
    logic        data_valid = 1'b0;

    logic [6:0] duan0, duan_lz, duan_low;
    logic [3:0] wei0, wei_lz, wei_low;
    logic       fd0, fd_lz, fd_low;

    int n_pass = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    seg7_scan_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0), .SEG_ACT_LOW(1'b0)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .sel_hi(sel_hi),
        .data_valid(data_valid), .sm_duan(duan0), .sm_wei(wei0), .frame_done(fd0)
    );
    seg7_scan_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1), .SEG_ACT_LOW(1'b0)) dut_lz (
        .clk(clk), .reset(reset), .data_in(data_in), .sel_hi(sel_hi),
        .data_valid(data_valid), .sm_duan(duan_lz), .sm_wei(wei_lz), .frame_done(fd_lz)
    );
    seg7_scan_display #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0), .SEG_ACT_LOW(1'b1)) dut_low (
        .clk(clk), .reset(reset), .data_in(data_in), .sel_hi(sel_hi),
        .data_valid(data_valid), .sm_duan(duan_low), .sm_wei(wei_low), .frame_done(fd_low)
    );

    // ---------------- model ----------------
    logic [6:0] glyph_tab [16];
    initial glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges since reset release, last captured halfword, value on display.
    int          m_edges = 0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_shown = 16'h0;

    function automatic logic [15:0] half_of(input logic [31:0] d, input logic s);
        return s ? d[31:16] : d[15:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_edges <= 0;
            m_pend  <= 16'h0;
            m_shown <= 16'h0;
        end else begin
            m_edges <= m_edges + 1;
            if (data_valid) m_pend <= half_of(data_in, sel_hi);
            if ((m_edges + 1) % FRAME == 0)
                m_shown <= data_valid ? half_of(data_in, sel_hi) : m_pend;
        end
    end

    function automatic int exp_digit(input int edges);
        return (edges / DIV) % 4;
    endfunction

    function automatic logic [6:0] exp_duan(input int edges, input logic [15:0] sh,
                                            input bit lz, input bit low);
        int d;
        logic [6:0] g;
        logic [15:0] upper;
        d = exp_digit(edges);
        g = glyph_tab[sh[d*4 +: 4]];
        upper = sh >> (d * 4);
        if (lz && d != 0 && upper == 16'h0) g = 7'h00;
        return low ? ~g : g;
    endfunction

    function automatic logic [3:0] exp_wei(input int edges, input bit low);
        logic [3:0] w;
        w = 4'b0001 << exp_digit(edges);
        return low ? ~w : w;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("m_wei0",   32'(wei0),    32'(exp_wei(m_edges, 1'b0)));
            check("m_duan0",  32'(duan0),   32'(exp_duan(m_edges, m_shown, 1'b0, 1'b0)));
            check("m_fd0",    32'(fd0),     32'((m_edges != 0) && (m_edges % FRAME == 0)));
            check("m_wei_lz", 32'(wei_lz),  32'(exp_wei(m_edges, 1'b0)));
            check("m_duan_lz",32'(duan_lz), 32'(exp_duan(m_edges, m_shown, 1'b1, 1'b0)));
            check("m_fd_lz",  32'(fd_lz),   32'((m_edges != 0) && (m_edges % FRAME == 0)));
            check("m_wei_low",32'(wei_low), 32'(exp_wei(m_edges, 1'b1)));
            check("m_duan_low",32'(duan_low),32'(exp_duan(m_edges, m_shown, 1'b0, 1'b1)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_valid(input logic [31:0] d, input logic s);
        data_in    = d;
        sel_hi     = s;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (fd0) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_frame_seen"}, 32'(found), 32'd1);
    endtask

    // Called at the frame_done negedge: checks all four digit slots.
    task automatic check_frame(input string name,
                               input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3,
                               input logic [6:0] l0, input logic [6:0] l1,
                               input logic [6:0] l2, input logic [6:0] l3);
        logic [6:0] g [4];
        logic [6:0] l [4];
        g = '{g0, g1, g2, g3};
        l = '{l0, l1, l2, l3};
        for (int k = 0; k < 4; k++) begin
            if (k != 0) repeat (DIV) @(negedge clk);
            check($sformatf("%s_d%0d_wei", name, k),  32'(wei0),    32'(4'b0001 << k));
            check($sformatf("%s_d%0d_duan", name, k), 32'(duan0),   32'(g[k]));
            check($sformatf("%s_d%0d_lz", name, k),   32'(duan_lz), 32'(l[k]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset held, then released
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wei",      32'(wei0),     32'h1);
        check("rst_duan",     32'(duan0),    32'h3F);
        check("rst_fd",       32'(fd0),      32'h0);
        check("rst_low_wei",  32'(wei_low),  32'hE);
        check("rst_low_duan", 32'(duan_low), 32'h40);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rel_wei_hold", 32'(wei0), 32'h1);
        @(negedge clk);
        check("rel_wei_step", 32'(wei0), 32'h2);

        // 2. low halfword of 1234ABCD
        pulse_valid(32'h1234ABCD, 1'b0);
        wait_frame("lo");
        check_frame("lo", 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h5E, 7'h39, 7'h7C, 7'h77);

        // 3. high halfword of the same word
        pulse_valid(32'h1234ABCD, 1'b1);
        wait_frame("hi");
        check_frame("hi", 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h66, 7'h4F, 7'h5B, 7'h06);

        // 4a. valid mid-frame leaves the current frame alone
        wait_frame("mid");
        repeat (2) @(negedge clk);
        pulse_valid(32'h0000_5A5A, 1'b0);
        @(negedge clk);
        check("mid_unchanged_wei",  32'(wei0),  32'h2);
        check("mid_unchanged_duan", 32'(duan0), 32'h4F);
        wait_frame("mid_next");
        check("mid_next_duan", 32'(duan0), 32'h77);

        // 4b. valid exactly on the boundary edge bypasses into shown
        repeat (FRAME - 1) @(negedge clk);
        data_in    = 32'h9876_0000;
        sel_hi     = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("byp_fd", 32'(fd0), 32'h1);
        check_frame("byp", 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h7D, 7'h07, 7'h7F, 7'h6F);

        // 5. leading-zero blanking
        pulse_valid(32'h0000_0050, 1'b0);
        wait_frame("lz");
        check_frame("lz", 7'h3F, 7'h6D, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h00, 7'h00);

        // 6. asynchronous reset while digit 2 is lit
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                if (wei0 == 4'b0100) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("ar_digit2_seen", 32'(seen), 32'd1);
        end
        #2 reset = 1'b1;
        #1;
        check("ar_wei",      32'(wei0),     32'h1);
        check("ar_duan",     32'(duan0),    32'h3F);
        check("ar_fd",       32'(fd0),      32'h0);
        check("ar_low_wei",  32'(wei_low),  32'hE);
        check("ar_low_duan", 32'(duan_low), 32'h40);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_frame("ar");
        check_frame("ar", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00, 7'h00, 7'h00);

        repeat (2) @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
